// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned BIT_IDX_W    = $clog2(DATA_BITS);
  localparam int unsigned MIN_BAUD_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: load half or full period, tick when it reaches zero.
module uart_baud_cnt #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_half_i,
  input  logic load_full_i,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(BAUD_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_full_i) begin
      cnt_d = CW'(BAUD_DIV - 1);
    end else if (load_half_i) begin
      cnt_d = CW'(BAUD_DIV / 2 - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output and overrun/framing pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_HZ, BAUD);

  if (BAUD_DIV < MIN_BAUD_DIV) begin : g_div_check
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  uart_state_e            state_q, state_d;
  logic                   rxd_q;
  logic                   rxd_vld_q;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;
  logic                   load_half, load_full, tick, done_c;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
`endif

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_half_i(load_half),
    .load_full_i(load_full),
    .tick_c     (tick)
  );

  // Frame sequencing and output handshake.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~rx_ready;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    load_half = 1'b0;
    load_full = 1'b0;
    done_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // rxd_vld_q keeps the reset value of rxd_q from posing as a real high level
        if (rxd_vld_q && rxd_q && !rxd) begin
          state_d   = ST_START;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rxd) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            load_full = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rxd, shift_q[DATA_BITS-1:1]};
          load_full = 1'b1;
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          par_bad_d = rxd ^ (^shift_q);
          load_full = 1'b1;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          if (rxd) begin
            done_c = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_c) begin
      if (valid_q && !rx_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_bad_q;
`endif
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rxd_q     <= 1'b1;
      rxd_vld_q <= 1'b0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rxd_q     <= rxd;
      rxd_vld_q <= 1'b1;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (directed table, corner sequences, random frames).
module tb_uart_rx;

  localparam int DIV  = 50000000 / 115200;
  localparam int HALF = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled mid-cycle.
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (overrun === 1'b1)   n_ovr  <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) n_perr <= n_perr + 1;
`endif
  end

  int total = 0, bad = 0;

  // Reference model: the byte the consumer would see and whether it is still pending.
  logic       mv = 1'b0;
  logic [7:0] md = 8'h00;

  typedef struct {
    logic [7:0] b;
    logic       stop_b;
    logic       rdy;
    logic       rdone;
    logic       exp_v;
    logic [7:0] exp_d;
    int         exp_f;
    int         exp_o;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one frame starting at a negedge; rdone raises rx_ready only on the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                            input logic rdy, input logic rdone);
    logic [11:0] bits;
    int nb, done_cyc;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    nb        = 10 + PAR;
    if (PAR != 0) begin
      bits[9]  = par_b;
      bits[10] = stop_b;
    end else begin
      bits[9] = stop_b;
    end
    done_cyc = cyc + 1 + HALF + (9 + PAR) * DIV;
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < DIV; k++) begin
        rxd      = bits[i];
        rx_ready = rdy | (rdone && (cyc + 1 == done_cyc));
        @(negedge clk);
      end
    end
    rxd      = 1'b1;
    rx_ready = rdy;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic stop_b,
                           input logic pflip, input logic rdy, input logic rdone,
                           input logic use_tbl, input vec_t v);
    int f0, o0, p0, ef, eo, ep;
    logic       ev;
    logic [7:0] ed;
    ef = stop_b ? 0 : 1;
    eo = 0;
    ep = 0;
    if (rdy) mv = 1'b0;
    if (stop_b) begin
      if (mv && !(rdy || rdone)) begin
        eo = 1;
      end else begin
        md = b;
        mv = 1'b1;
        ep = (PAR != 0 && pflip) ? 1 : 0;
      end
      if (rdy) mv = 1'b0;
    end
    ev = mv;
    ed = md;
    if (use_tbl) begin
      ev = v.exp_v;
      ed = v.exp_d;
      ef = v.exp_f;
      eo = v.exp_o;
    end
    f0 = n_ferr;
    o0 = n_ovr;
    p0 = n_perr;
    send_frame(b, stop_b, (^b) ^ pflip, rdy, rdone);
    check({tag, ".valid"}, 32'(rx_valid), 32'(ev));
    check({tag, ".data"}, 32'(rx_data), 32'(ed));
    check({tag, ".frame_err"}, 32'(n_ferr - f0), 32'(ef));
    check({tag, ".overrun"}, 32'(n_ovr - o0), 32'(eo));
    check({tag, ".busy"}, 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_err"}, 32'(n_perr - p0), 32'(ep));
`else
    if (p0 != n_perr) check({tag, ".parity_err"}, 32'(n_perr - p0), 32'd0);
`endif
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    mv = 1'b0;
    check("drain.valid", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, ex, f0;
    vec_t dummy;
    dummy = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};

    tbl[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 0};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 0, 0};
    tbl[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 0, 1};
    tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 0, 0};
    tbl[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 0, 0};
    tbl[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0};
    tbl[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 0};

    // Reset with the line held low: reset values, then no frame may start.
    reset_n  = 1'b0;
    rxd      = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.rx_data", 32'(rx_data), 32'd0);
    check("rst.rx_valid", 32'(rx_valid), 32'd0);
    check("rst.frame_err", 32'(frame_err), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("held_low.busy", 32'(busy), 32'd0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 8'hA5 with exact delivery timing.
    e0 = cyc + 1;
    ex = e0 + HALF + (9 + PAR) * DIV;
    fork
      run_frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
      begin
        while (cyc < ex - 1) @(negedge clk);
        check("a5.pre_valid", 32'(rx_valid), 32'd0);
        @(negedge clk);
        check("a5.rise_valid", 32'(rx_valid), 32'd1);
        check("a5.rise_data", 32'(rx_data), 32'hA5);
      end
    join

    // 100-cycle low glitch is a false start.
    drain();
    f0 = n_ferr;
    e0 = cyc + 1;
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    while (cyc < e0 + HALF - 1) @(negedge clk);
    check("glitch.busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    check("glitch.busy_after", 32'(busy), 32'd0);
    check("glitch.valid", 32'(rx_valid), 32'd0);
    check("glitch.frame_err", 32'(n_ferr - f0), 32'd0);
    repeat (4) @(negedge clk);

    // Directed table: framing error, overrun, same-cycle consume, ready-high delivery.
    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].stop_b, 1'b0, tbl[i].rdy,
                tbl[i].rdone, 1'b1, tbl[i]);
    end

    // Random frames checked against the model.
    for (int r = 0; r < 2; r++) begin
      logic [7:0] b;
      logic       sb, rd;
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", r), b, sb, 1'b0, rd, 1'b0, 1'b0, dummy);
    end

    // Reset in the middle of data bit 4 of 8'hFF, then a clean 8'h5A.
    rx_ready = 1'b0;
    e0 = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      begin
        while (cyc < e0 + 5 * DIV + 10) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst.rx_data", 32'(rx_data), 32'd0);
        check("midrst.rx_valid", 32'(rx_valid), 32'd0);
        check("midrst.frame_err", 32'(frame_err), 32'd0);
        check("midrst.overrun", 32'(overrun), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
    join
    mv = 1'b0;
    md = 8'h00;
    check("midrst.no_partial", 32'(rx_valid), 32'd0);
    run_frame("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dummy);

`ifdef UART_RX_PARITY_EN
    // 8'h07 with parity bit 0: delivered with a parity error.
    run_frame("par07", 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, dummy);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
